// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit von Neumann RISC: owns PC and IR,
// arbitrates the shared memory port and turns control-unit decisions into phase-qualified strobes.
module fetch_sequencer #(
  parameter int              ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              WAIT_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  input  logic [15:0]       mem_rdata_in,
  input  logic              mem_ready_in,
  output logic [3:0]        opcode_out,
  output logic [15:0]       instr_out,
  input  logic              reg_write_enable_in,
  input  logic              mem_write_enable_in,
  input  logic              mem_to_reg_select_in,
  input  logic              mem_address_select_in,
  input  logic              jump_enable_in,
  input  logic              branch_enable_in,
  input  logic              halt_cpu_in,
  input  logic              alu_zero_flag_in,
  input  logic [15:0]       alu_result_in,
  output logic [ADDR_W-1:0] pc_out,
  output logic              reg_write_strobe_out,
  output logic              halted_out,
  output logic              fault_out
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_HALT
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_LIMIT - 1);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       ir;
  logic [3:0]        wait_cnt;
  logic              fault;

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] branch_offset;
  logic [ADDR_W-1:0] data_addr;
  logic              wait_expired;
  logic              unused_alu_bits;

  assign pc_inc          = pc + ADDR_W'(1);
  assign branch_offset   = ADDR_W'({{8{ir[7]}}, ir[7:0]});
  assign data_addr       = alu_result_in[ADDR_W-1:0];
  assign wait_expired    = (wait_cnt == WAIT_LAST);
  assign unused_alu_bits = ^alu_result_in[15:ADDR_W];

  // PC is already incremented when EXECUTE runs, so the branch offset is relative to PC+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      ir       <= 16'h0000;
      wait_cnt <= 4'd0;
      fault    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every branch below sees
      // the pre-edge values of pc/ir/wait_cnt regardless of statement order.
      wait_cnt <= 4'd0;
      unique case (state)
        S_FETCH: begin
          if (mem_ready_in) begin
            ir    <= mem_rdata_in;
            pc    <= pc_inc;
            state <= S_DECODE;
          end else if (wait_expired) begin
            fault <= 1'b1;
            state <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_DECODE: state <= S_EXECUTE;
        S_EXECUTE: begin
          if (halt_cpu_in) begin
            state <= S_HALT;
          end else if (jump_enable_in) begin
            pc    <= ir[ADDR_W-1:0];
            state <= S_FETCH;
          end else if (branch_enable_in) begin
            if (alu_zero_flag_in) pc <= pc + branch_offset;
            state <= S_FETCH;
          end else if (mem_address_select_in) begin
            state <= S_MEM;
          end else begin
            state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (mem_ready_in) begin
            state <= S_FETCH;
          end else if (wait_expired) begin
            fault <= 1'b1;
            state <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Requests and strobes follow the current phase in the same cycle; reset masks them so an
  // aborted access never produces a strobe.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves one unassigned
    // and no latch is inferred.
    mem_addr_out         = pc;
    mem_read_out         = 1'b0;
    mem_write_out        = 1'b0;
    reg_write_strobe_out = 1'b0;
    if (!rst) begin
      unique case (state)
        S_FETCH: mem_read_out = 1'b1;
        S_EXECUTE: begin
          if (!halt_cpu_in && !jump_enable_in && !branch_enable_in && !mem_address_select_in)
            reg_write_strobe_out = reg_write_enable_in;
        end
        S_MEM: begin
          mem_addr_out         = data_addr;
          mem_read_out         = mem_to_reg_select_in;
          mem_write_out        = mem_write_enable_in;
          reg_write_strobe_out = mem_ready_in && mem_to_reg_select_in && !mem_write_enable_in;
        end
        default: ;
      endcase
    end
  end

  assign opcode_out = ir[15:12];
  assign instr_out  = ir;
  assign pc_out     = pc;
  assign halted_out = (state == S_HALT);
  assign fault_out  = fault;

endmodule
